// File: rtl/bram_arbiter.sv
// Two-master arbiter for one single-port BRAM with round-robin, burst-limited priority.
// Ports: clk/rst; m0_*/m1_* request side (req, we, addr, din, gnt, rvalid, rdata); BRAM side (addr, en, we, din, qout).
module bram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 2**12-1,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  en,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] qout
);
    localparam int CW = $clog2(MAX_BURST+1);
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state;
    logic            last_id;
    logic [CW-1:0]   beat_cnt;
    logic            rd_pend;
    logic            rd_id;

    logic            sel;
    logic            fire;
    logic            keep0;
    logic            keep1;
    logic            same_owner;
    logic            we_sel;

    // The current owner keeps the grant until it stops requesting or
    // has used up its burst while the other master is waiting.
    assign keep0 = (state == OWN0) && m0_req && (!m1_req || beat_cnt < MAX_B);
    assign keep1 = (state == OWN1) && m1_req && (!m0_req || beat_cnt < MAX_B);

    always_comb begin
        sel  = 1'b0;
        fire = 1'b0;
        if (keep0) begin
            fire = 1'b1;
        end else if (keep1) begin
            sel  = 1'b1;
            fire = 1'b1;
        end else if (m0_req && m1_req) begin
            sel  = ~last_id;
            fire = 1'b1;
        end else if (m0_req) begin
            fire = 1'b1;
        end else if (m1_req) begin
            sel  = 1'b1;
            fire = 1'b1;
        end
        if (rst) fire = 1'b0;
    end

    assign same_owner = (state == OWN0 && !sel) || (state == OWN1 && sel);
    assign we_sel     = sel ? m1_we : m0_we;

    assign m0_gnt = fire && !sel;
    assign m1_gnt = fire && sel;
    assign en     = fire;
    assign we     = fire && we_sel;
    assign addr   = fire ? (sel ? m1_addr : m0_addr) : '0;
    assign din    = fire ? (sel ? m1_din : m0_din) : '0;

    // Read data is shared; rvalid steers it. Reset hides a pending read.
    assign m0_rvalid = rd_pend && !rst && !rd_id;
    assign m1_rvalid = rd_pend && !rst && rd_id;
    assign m0_rdata  = qout;
    assign m1_rdata  = qout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_id  <= 1'b1;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else if (fire) begin
            state   <= sel ? OWN1 : OWN0;
            last_id <= sel;
            if (!same_owner)
                beat_cnt <= CW'(1);
            else if (beat_cnt != MAX_B)
                beat_cnt <= beat_cnt + 1'b1;
            rd_pend <= !we_sel;
            rd_id   <= sel;
        end else begin
            state    <= IDLE;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed scenarios plus random traffic.
// A behavioural arbitration/memory model predicts grants and read returns.
module tb_bram_arbiter;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_din = '0, m1_din = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] addr;
    logic          en, we;
    logic [DW-1:0] din;
    logic [DW-1:0] qout = '0;

    bram_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .addr(addr), .en(en), .we(we), .din(din), .qout(qout)
    );

    always #5 clk = ~clk;

    // BRAM instance model
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    qout <= mem[addr];
        end
    end

    typedef struct {
        int cyc;
        bit g0, g1, en, we;
        int addr, din;
    } exp_t;
    typedef struct {
        int due;
        int data;
    } rd_t;

    exp_t cq[$];
    rd_t  rq0[$];
    rd_t  rq1[$];
    int   shadow [4096];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference arbitration state: owner -1 = nobody
    int owner = -1;
    int run = 0;
    int last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, req);
        end
    endtask

    // Apply one cycle of inputs and predict what the DUT must do.
    task automatic step(input bit r, input bit r0, input bit w0, input int a0, input int d0,
                        input bit r1, input bit w1, input int a1, input int d1,
                        output int g);
        exp_t e;
        rd_t  x;
        bit   rq [2];
        bit   wq [2];
        int   aq [2];
        int   dq [2];
        @(posedge clk);
        #1;
        rst = r;
        m0_req = r0; m0_we = w0; m0_addr = AW'(a0); m0_din = DW'(d0);
        m1_req = r1; m1_we = w1; m1_addr = AW'(a1); m1_din = DW'(d1);
        rq[0] = r0; rq[1] = r1; wq[0] = w0; wq[1] = w1;
        aq[0] = a0; aq[1] = a1; dq[0] = d0; dq[1] = d1;
        g = -1;
        if (r) begin
            owner = -1; run = 0; last = 1;
            rq0.delete(); rq1.delete();
        end else begin
            if (owner >= 0 && rq[owner] && (!rq[1-owner] || run < MB)) g = owner;
            else if (r0 && r1) g = 1 - last;
            else if (r0) g = 0;
            else if (r1) g = 1;
            if (g >= 0) begin
                run = (g == owner) ? ((run < MB) ? run + 1 : MB) : 1;
                owner = g;
                last = g;
            end else begin
                owner = -1;
                run = 0;
            end
        end
        e.cyc = cyc;
        e.g0 = (g == 0); e.g1 = (g == 1); e.en = (g >= 0);
        e.we = (g >= 0) && wq[g < 0 ? 0 : g];
        e.addr = (g >= 0) ? aq[g] : 0;
        e.din  = (g >= 0) ? dq[g] : 0;
        cq.push_back(e);
        if (g >= 0) begin
            if (wq[g]) begin
                shadow[aq[g]] = dq[g];
            end else begin
                x.due = cyc + 1;
                x.data = shadow[aq[g]];
                if (g == 0) rq0.push_back(x);
                else        rq1.push_back(x);
            end
        end
    endtask

    // Monitor: compares DUT outputs against queued predictions.
    initial begin
        exp_t e;
        bit   ex;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("m0_gnt", int'(m0_gnt), int'(e.g0));
                chk("m1_gnt", int'(m1_gnt), int'(e.g1));
                chk("en", int'(en), int'(e.en));
                chk("we", int'(we), int'(e.we));
                chk("addr", int'(addr), e.addr);
                chk("din", int'(din), e.din);
            end
            ex = (rq0.size() > 0 && rq0[0].due == cyc);
            chk("m0_rvalid", int'(m0_rvalid), int'(ex));
            if (ex) begin
                chk("m0_rdata", int'(m0_rdata), rq0[0].data);
                void'(rq0.pop_front());
            end
            ex = (rq1.size() > 0 && rq1[0].due == cyc);
            chk("m1_rvalid", int'(m1_rvalid), int'(ex));
            if (ex) begin
                chk("m1_rdata", int'(m1_rdata), rq1[0].data);
                void'(rq1.pop_front());
            end
        end
    end

    initial begin
        int g;
        bit p0, p1, w0, w1;
        int a0, a1, d0, d1;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            shadow[i] = 0;
        end
        // reset
        step(1, 0,0,0,0, 0,0,0,0, g);
        step(1, 0,0,0,0, 0,0,0,0, g);
        // m0 alone: write 5..8 then read back
        for (int i = 0; i < 4; i++) step(0, 1,1,5+i,'hA5+i, 0,0,0,0, g);
        for (int i = 0; i < 4; i++) step(0, 1,0,5+i,0, 0,0,0,0, g);
        step(0, 0,0,0,0, 0,0,0,0, g);
        // tie after reset, then continuous contention
        step(1, 0,0,0,0, 0,0,0,0, g);
        for (int i = 0; i < 12; i++) step(0, 1,0,5+(i%4),0, 1,0,6,0, g);
        // m1 owns mid-burst (2 beats), then drops with m0 waiting
        step(0, 0,0,0,0, 0,0,0,0, g);
        step(0, 0,0,0,0, 1,0,7,0, g);
        step(0, 1,0,5,0, 1,0,8,0, g);
        step(0, 1,0,5,0, 0,0,0,0, g);
        step(0, 1,0,6,0, 0,0,0,0, g);
        // write from m0 then read of the same word by m1
        step(0, 1,1,10,'h3C, 0,0,0,0, g);
        step(0, 0,0,0,0, 1,0,10,0, g);
        step(0, 0,0,0,0, 0,0,0,0, g);
        // reset right after an m1 read grant
        step(0, 0,0,0,0, 1,0,10,0, g);
        step(1, 1,0,5,0, 1,0,6,0, g);
        step(0, 1,0,5,0, 1,0,6,0, g);
        step(0, 0,0,0,0, 0,0,0,0, g);
        // random traffic with requests held until granted
        p0 = 0; p1 = 0;
        w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!p0 && $urandom_range(0, 9) < 7) begin
                p0 = 1; w0 = 1'($urandom); a0 = $urandom_range(0, 15); d0 = $urandom_range(0, 255);
            end
            if (!p1 && $urandom_range(0, 9) < 7) begin
                p1 = 1; w1 = 1'($urandom); a1 = $urandom_range(0, 15); d1 = $urandom_range(0, 255);
            end
            step(($urandom_range(0, 199) == 0), p0,w0,a0,d0, p1,w1,a1,d1, g);
            if (rst) begin
                p0 = 0; p1 = 0;
            end
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
        end
        step(0, 0,0,0,0, 0,0,0,0, g);
        step(0, 0,0,0,0, 0,0,0,0, g);
        @(posedge clk);
        @(negedge clk);
        chk("drain_m0", rq0.size(), 0);
        chk("drain_m1", rq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester arbiter sharing one single-port BRAM (1-cycle read latency) between masters m0 and m1.
- Issues at most one BRAM access per cycle and uses round-robin priority with bounded burst hold.
- Routes each read result back to the requester that issued it.
- Sits between the BRAM controller/DMA-style masters and the BRAM instance.

Parameters:
- DATA_WIDTH, 8, BRAM word width.
- MEM_SIZE, 2**12-1, BRAM depth in words.
- ADDR_WIDTH, $clog2(MEM_SIZE), BRAM address width.
- MAX_BURST, 4, maximum consecutive beats an owner keeps the grant while the other master requests (>=1).

Ports:
- clk  input  1  single clock; everything is on posedge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  m0 access request, held until granted.
- m0_we  input  1  m0 write enable (1=write, 0=read).
- m0_addr  input  ADDR_WIDTH  m0 address.
- m0_din  input  DATA_WIDTH  m0 write data.
- m0_gnt  output  1  m0 access accepted this cycle.
- m0_rvalid  output  1  m0 read data valid.
- m0_rdata  output  DATA_WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_din, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- addr  output  ADDR_WIDTH  BRAM address.
- en  output  1  BRAM enable.
- we  output  1  BRAM write enable.
- din  output  DATA_WIDTH  BRAM write data.
- qout  input  DATA_WIDTH  BRAM read data, valid the cycle after a read.

Behaviour:
- Clock and reset: one clock, clk. Synchronous, active-high reset rst.
- Reset state while rst=1 and on the next edge: state=IDLE, last_id=1, beat_cnt=0, rd_pend=0. All gnt, en, we, rvalid are forced to 0; addr/din are forced to 0.
- Transfer rule:
  - A beat fires in any cycle where mk_req && mk_gnt.
  - gnt is combinational from registered state and current req; zero-cycle grant is allowed.
  - A requester holds req/we/addr/din stable until gnt is seen.
- FSM states: IDLE (no owner), OWN0, OWN1. beat_cnt is $clog2(MAX_BURST+1) bits and counts consecutive beats by the current owner.
- Combinational selection, in priority order:
  - (a) In state OWNk with mk_req=1 and (other req=0 or beat_cnt<MAX_BURST): sel=k.
  - (b) Else if both requesters request: sel = the requester != last_id.
  - (c) Else if exactly one requests: sel = that one.
  - (d) Else no grant.
- Registered update on each clock edge:
  - If a beat fires: state<=OWN[sel]; last_id<=sel; beat_cnt<=beat_cnt+1 (saturating at MAX_BURST) if sel equals the current owner, else beat_cnt<=1.
  - If no beat fires: state<=IDLE; beat_cnt<=0; last_id is unchanged.
- BRAM drive:
  - en=1 only in a cycle with a granted beat.
  - we, addr, din are muxed from the selected master.
  - When en=0: we=0, addr=0, din=0.
- Read return:
  - rd_pend<=(beat fires && !we_sel); rd_id<=sel.
  - The next cycle, mk_rvalid = rd_pend && (rd_id==k).
  - m0_rdata and m1_rdata both equal qout; rvalid qualifies them.
  - Read latency is exactly 1 cycle from the grant cycle. Back-to-back reads from alternating masters return in issue order, with no bubble.
- Writes: complete in the grant cycle; no response is generated.
- Fairness: under continuous contention, grants alternate in bursts of exactly MAX_BURST beats. Neither master waits more than MAX_BURST cycles.
- When the owner drops req, the other master is granted in the same cycle (rule c) with no idle cycle.
- Reset mid-operation: a pending read is discarded and rvalid does not assert after rst.
- Width rules: no address or data arithmetic; the beat_cnt saturation prevents wrap.

Test Plan:
- Single master: m0 writes addr 5..8 with data 0xA5..0xA8 (m1 idle), then reads them back. Required: m0_gnt=1 every cycle, en=1, m0_rvalid one cycle after each read grant with rdata 0xA5..0xA8, m1_rvalid=0 throughout.
- Tie after reset: m0_req=m1_req=1 in the first cycle. Required: m0 granted first (last_id reset=1).
- Continuous contention, MAX_BURST=4, both reading: grants are m0×4, m1×4, m0×4. Each rvalid lands on the correct master one cycle after its grant.
- Owner drop: m1 owns in mid-burst, m1_req falls while m0_req=1. Required: m0_gnt=1 in that same cycle, state=OWN0, beat_cnt=1.
- Interleaved read/write: m0 writes 0x3C to addr 10 while m1 reads addr 10 in the following cycle. Required: m1_rvalid=1 with rdata=0x3C, m0_rvalid=0.
- Reset mid-read: assert rst in the cycle after an m1 read grant. Required: m1_rvalid=0, all gnt/en=0 while rst=1, and the post-reset tie goes to m0.
